// File: rtl/io_pwm_led_if.sv
// CPU store-to-IO bus as seen by IO peripherals: byte enables, word address, write data.
interface io_pwm_led_if;
  logic [3:0]  st_we_io;
  logic [9:0]  st_adr_io;
  logic [31:0] st_data_io;

  modport master (output st_we_io, st_adr_io, st_data_io);
  modport slave  (input  st_we_io, st_adr_io, st_data_io);
endinterface

// File: rtl/io_pwm_led.sv
// N-channel LED driver with static/PWM/blink modes, shared prescaler and PWM counter,
// double-buffered duty and a period-end interrupt, programmed over the store-to-IO bus.
module io_pwm_led #(
  parameter int       CHANNELS = 3,
  parameter int       PWM_BITS = 8,
  parameter bit [9:0] BASE_ADR = 10'h380,
  parameter bit       LED_POL  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  io_pwm_led_if.slave         bus,
  output logic [CHANNELS-1:0] led,
  output logic                irq
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  // Bus decode
  logic        wr;
  logic [9:0]  rel_adr;
  logic        ctrl_wr;
  logic        pre_wr;
  logic        irq_clr;

  assign wr      = |bus.st_we_io;
  assign rel_adr = bus.st_adr_io - BASE_ADR;
  assign ctrl_wr = wr && (rel_adr == 10'd0);
  assign pre_wr  = wr && (rel_adr == 10'd1);
  assign irq_clr = ctrl_wr && bus.st_we_io[3] && bus.st_data_io[31];

  // Shared timebase
  logic                ctrl_en;
  logic                ctrl_irq_en;
  logic [15:0]         prescale;
  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                period_end;
  logic [CHANNELS-1:0] on_vec;

  assign tick       = ctrl_en && (pre_cnt == prescale);
  assign period_end = tick && (pwm_cnt == '1);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      prescale    <= '0;
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      irq         <= 1'b0;
      led         <= {CHANNELS{~LED_POL}};
    end else begin
      if (ctrl_wr && bus.st_we_io[0]) begin
        ctrl_en     <= bus.st_data_io[0];
        ctrl_irq_en <= bus.st_data_io[1];
      end
      if (pre_wr && bus.st_we_io[0]) prescale[7:0]  <= bus.st_data_io[7:0];
      if (pre_wr && bus.st_we_io[1]) prescale[15:8] <= bus.st_data_io[15:8];

      // Only equality is tested: a PRESCALE written below pre_cnt runs through the 16-bit wrap.
      if (!ctrl_en) begin
        pre_cnt <= '0;
        pwm_cnt <= '0;
      end else begin
        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      end

      // A period end coinciding with a clear leaves the interrupt pending.
      if (period_end && ctrl_irq_en) irq <= 1'b1;
      else if (irq_clr)              irq <= 1'b0;

      led <= on_vec ^ {CHANNELS{~LED_POL}};
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic                ch_wr;
    logic [PWM_BITS-1:0] duty_shadow;
    logic [PWM_BITS-1:0] active_duty;
    mode_e               mode;
    logic [7:0]          blink_div;
    logic [7:0]          blink_cnt;
    logic                blink_state;
    logic                pwm_on;
    logic                on;

    assign ch_wr  = wr && (rel_adr == 10'(i + 2));
    assign pwm_on = pwm_cnt < active_duty;

    // NOTE: every per-channel register, config included, is reset so the map reads as all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_shadow <= '0;
        active_duty <= '0;
        mode        <= MODE_OFF;
        blink_div   <= '0;
        blink_cnt   <= '0;
        blink_state <= 1'b0;
      end else begin
        if (ch_wr && bus.st_we_io[0]) duty_shadow <= bus.st_data_io[PWM_BITS-1:0];
        if (ch_wr && bus.st_we_io[1]) mode        <= mode_e'(bus.st_data_io[9:8]);
        if (ch_wr && bus.st_we_io[2]) blink_div   <= bus.st_data_io[23:16];

        // Duty swaps only at the period boundary so a running cycle never glitches.
        if (!ctrl_en || period_end) active_duty <= duty_shadow;

        if (!ctrl_en) begin
          blink_cnt   <= '0;
          blink_state <= 1'b0;
        end else if (period_end) begin
          if (blink_cnt == blink_div) begin
            blink_cnt   <= '0;
            blink_state <= ~blink_state;
          end else begin
            blink_cnt <= blink_cnt + 8'd1;
          end
        end
      end
    end

    // NOTE: default assignment first keeps this block combinational for every mode value.
    always_comb begin
      on = 1'b0;
      case (mode)
        MODE_OFF:   on = 1'b0;
        MODE_ON:    on = 1'b1;
        MODE_PWM:   on = pwm_on;
        MODE_BLINK: on = blink_state && pwm_on;
        default:    on = 1'b0;
      endcase
    end

    assign on_vec[i] = ctrl_en && on;
  end

endmodule

// File: tb/tb_io_pwm_led.sv
// Directed bench for io_pwm_led: reset, PWM duty, double-buffered duty, blink,
// byte enables, interrupt set/clear priority and asynchronous reset.
module tb_io_pwm_led;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] led;
  logic       irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_pwm_led_if bus ();

  io_pwm_led #(
    .CHANNELS (3),
    .PWM_BITS (8),
    .BASE_ADR (10'h380),
    .LED_POL  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led),
    .irq   (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] adr, input logic [31:0] data, input logic [3:0] we);
    bus.st_adr_io  = adr;
    bus.st_data_io = data;
    bus.st_we_io   = we;
  endtask

  task automatic write(input logic [9:0] adr, input logic [31:0] data, input logic [3:0] we);
    drive(adr, data, we);
    @(posedge clk);
    @(negedge clk);
    drive(10'd0, 32'd0, 4'd0);
  endtask

  // One full 256-cycle PWM period starting at a period boundary; optional write on step wr_j.
  // Sample j-1 holds the pin value produced from pwm_cnt == j-1.
  task automatic period(input int wr_j, input logic [9:0] adr, input logic [31:0] data,
                        input logic [3:0] we, output logic [255:0] t0, output logic [255:0] t1,
                        output logic [255:0] t2, output logic [255:0] ti);
    for (int j = 1; j <= 256; j++) begin
      if (j == wr_j) drive(adr, data, we);
      else           drive(10'd0, 32'd0, 4'd0);
      @(posedge clk);
      @(negedge clk);
      t0[j-1] = led[0];
      t1[j-1] = led[1];
      t2[j-1] = led[2];
      ti[j-1] = irq;
    end
    drive(10'd0, 32'd0, 4'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] t0, t1, t2, ti;
    int n;

    drive(10'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Configure while disabled: PRESCALE=0, CH0 pwm duty 64, CH2 pwm duty 16
    write(10'h381, 32'h0000_0000, 4'b0011);
    write(10'h382, 32'h0000_0240, 4'b0111);
    write(10'h384, 32'h0000_0210, 4'b0111);
    repeat (4) @(negedge clk);
    check("disabled_led", 32'(led), 32'h0);
    check("disabled_irq", 32'(irq), 32'h0);

    // EN=1, IRQ_EN=1; first period end is 256 ticks later
    write(10'h380, 32'h0000_0003, 4'b0001);
    n = 0;
    while (irq !== 1'b1 && n < 600) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("irq_first_period_cycles", 32'(n), 32'd256);

    // A: CH1 blink (duty 255, div 1) written mid-period
    period(10, 10'h383, 32'h0001_03FF, 4'b0111, t0, t1, t2, ti);
    check("A_ch0_count", 32'($countones(t0)), 32'd64);
    check("A_ch0_first", 32'(t0[0]), 32'h1);
    check("A_ch0_last_on", 32'(t0[63]), 32'h1);
    check("A_ch0_first_off", 32'(t0[64]), 32'h0);
    check("A_ch1_count", 32'($countones(t1)), 32'd0);
    check("A_ch2_count", 32'($countones(t2)), 32'd16);

    // B: CH0 duty 64 -> 192 mid-period, old duty holds until the wrap
    period(100, 10'h382, 32'h0000_02C0, 4'b0011, t0, t1, t2, ti);
    check("B_ch0_count", 32'($countones(t0)), 32'd64);
    check("B_ch0_after_write", 32'(t0[150]), 32'h0);
    check("B_ch1_count", 32'($countones(t1)), 32'd255);
    check("B_ch1_max_off", 32'(t1[255]), 32'h0);

    // C: CH2 write with only byte 0 enabled -> duty 0x80 shadowed, mode/div untouched
    period(50, 10'h384, 32'h0001_0380, 4'b0001, t0, t1, t2, ti);
    check("C_ch0_count", 32'($countones(t0)), 32'd192);
    check("C_ch0_last_on", 32'(t0[191]), 32'h1);
    check("C_ch0_first_off", 32'(t0[192]), 32'h0);
    check("C_ch1_count", 32'($countones(t1)), 32'd0);
    check("C_ch2_count", 32'($countones(t2)), 32'd16);

    // D: IRQ clear coincident with period end -> stays pending
    period(256, 10'h380, 32'h8000_0000, 4'b1000, t0, t1, t2, ti);
    check("D_ch0_count", 32'($countones(t0)), 32'd192);
    check("D_ch1_count", 32'($countones(t1)), 32'd0);
    check("D_ch2_count", 32'($countones(t2)), 32'd128);
    check("D_ch2_last_on", 32'(t2[127]), 32'h1);
    check("D_ch2_first_off", 32'(t2[128]), 32'h0);
    check("D_irq_set_wins", 32'(ti[255]), 32'h1);

    // E: IRQ clear mid-period, re-set at the next period end
    period(5, 10'h380, 32'h8000_0000, 4'b1000, t0, t1, t2, ti);
    check("E_ch1_count", 32'($countones(t1)), 32'd255);
    check("E_ch2_count", 32'($countones(t2)), 32'd128);
    check("E_irq_before_clr", 32'(ti[3]), 32'h1);
    check("E_irq_cleared", 32'(ti[4]), 32'h0);
    check("E_irq_reset_at_end", 32'(ti[255]), 32'h1);

    // Asynchronous reset in the middle of a period
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("F_led_before_reset", 32'(led), 32'h7);
    check("F_irq_before_reset", 32'(irq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'h0);
    check("async_reset_irq", 32'(irq), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset only EN is set: modes and IRQ_EN came back as 0
    write(10'h380, 32'h0000_0001, 4'b0001);
    period(0, 10'h000, 32'h0, 4'b0000, t0, t1, t2, ti);
    check("post_reset_ch0", 32'($countones(t0)), 32'd0);
    check("post_reset_ch1", 32'($countones(t1)), 32'd0);
    check("post_reset_ch2", 32'($countones(t2)), 32'd0);
    check("post_reset_irq", 32'($countones(ti)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
